// File: rtl/nes_pll_reset_ctrl.sv
// rtl/nes_pll_reset_ctrl.sv - PLL reset/lock sequencer that gates the NES core reset
module nes_pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int MAX_RETRIES        = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       restart_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [3:0] retry_count_o,
  output logic [7:0] lock_lost_count_o
);

  localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                   : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX   = (LOCK_TIMEOUT > CNT_MAX_A) ? LOCK_TIMEOUT : CNT_MAX_A;
  localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       lost_q, lost_d;
  logic [1:0]       sync_q;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             lock_s;

  // LOCKED comes from the PLL domain; two flops before anything looks at it.
  assign lock_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;

    if (restart_i) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_q + 4'd1;
            cnt_d   = '0;
            state_d = (retry_q + 4'd1 == RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          retry_d = '0;
          if (!lock_s) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they settle on the same edge.
    pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      lost_q    <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      sync_q    <= {sync_q[0], pll_locked_i};
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst_o         = pll_rst_q;
  assign sys_rst_o         = sys_rst_q;
  assign ready_o           = ready_q;
  assign fail_o            = fail_q;
  assign retry_count_o     = retry_q;
  assign lock_lost_count_o = lost_q;

endmodule

// File: doc/nes_pll_reset_ctrl.md
# nes_pll_reset_ctrl

Controller on the initiator side of the NES clock generator's PLL `RST`/`LOCKED` interface. It drives the PLL reset, waits for lock with a timeout, and requires lock to stay stable before it releases the NES core reset. If lock is lost, it holds the core in reset and restarts the PLL. After repeated lock timeouts it latches a failure flag for the host.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before an attempt fails (≥2).
- `LOCK_STABLE_CYCLES`, 256: consecutive synchronized-lock cycles required before release (≥1).
- `MAX_RETRIES`, 4: consecutive timeouts that cause FAIL (1..15).

Ports:
- `clk` in 1: system clock, free-running and independent of the PLL.
- `rst` in 1: reset, synchronous and active-high.
- `pll_locked` in 1: PLL `LOCKED`. Asynchronous to `clk`; passes through a 2-flop synchronizer.
- `restart` in 1: single-cycle request to force a fresh PLL reset sequence.
- `pll_rst` out 1: drives PLL `RST`.
- `sys_rst` out 1: active-high reset to logic clocked by the PLL output clock.
- `ready` out 1: high only in RUN.
- `fail` out 1: high only in FAIL.
- `retry_count` out 4: consecutive timeouts in the current sequence.
- `lock_lost_count` out 8: number of lock losses seen in RUN; saturates at 255.

## Operation
- All outputs are registered.
- Reset values: state PLL_RST; `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `retry_count`=0, `lock_lost_count`=0. All counters are 0.
- `lock_s` is the synchronizer output. It trails `pll_locked` by 2 edges.
- States:
  - **PLL_RST**:
    - `pll_rst`=1, `sys_rst`=1.
    - Count `PLL_RST_CYCLES` cycles, then go to WAIT_LOCK with the timeout counter cleared.
  - **WAIT_LOCK**:
    - `pll_rst`=0.
    - If `lock_s`=1, go to STABLE with the stable counter cleared.
    - Otherwise, when the timeout counter reaches `LOCK_TIMEOUT`-1, increment `retry_count`. If the new value equals `MAX_RETRIES`, go to FAIL; else go to PLL_RST.
  - **STABLE**:
    - Count cycles while `lock_s`=1.
    - If `lock_s`=0, return to WAIT_LOCK with the timeout counter cleared and `retry_count` unchanged.
    - After `LOCK_STABLE_CYCLES` consecutive high cycles, go to RUN.
  - **RUN**:
    - `sys_rst`=0, `ready`=1, `retry_count` cleared to 0.
    - If `lock_s`=0: increment `lock_lost_count` (saturating), set `sys_rst`=1 and `ready`=0 on that edge, and go to PLL_RST.
  - **FAIL**:
    - `pll_rst`=1, `sys_rst`=1, `fail`=1.
    - Held until `rst` or `restart`.
- `restart`=1 in any state:
  - Go to PLL_RST and clear `retry_count`, `fail` and the phase counters.
  - `lock_lost_count` is preserved.
  - `restart` has priority over every other transition, including a simultaneous lock drop in RUN; in that case there is no count increment.
- `rst` mid-sequence returns everything to reset values on the next edge, including `lock_lost_count`.
- A `pll_locked` glitch shorter than one `clk` period may be missed. This is acceptable because the PLL holds lock loss for many cycles.

## Timing
- Edge 0 is the first edge with `rst`=0.
- `pll_rst` is high through edge `PLL_RST_CYCLES`-1 and low from edge `PLL_RST_CYCLES`.
- Release latency: `pll_locked` first sampled high at edge k, and held high, gives `sys_rst`=0 and `ready`=1 at edge k+`LOCK_STABLE_CYCLES`+3. This is 2 synchronizer edges, 1 WAIT_LOCK→STABLE edge, and `LOCK_STABLE_CYCLES` edges in STABLE.
- Lock-loss latency: `pll_locked` falls at edge k in RUN; `sys_rst`=1 at edge k+3 and `pll_rst`=1 at edge k+3.
- Timeout: the WAIT_LOCK dwell is exactly `LOCK_TIMEOUT` cycles.
- Full attempt period with no lock = `PLL_RST_CYCLES` + `LOCK_TIMEOUT` cycles.
- `restart` sampled at edge k gives `pll_rst`=1 and `sys_rst`=1 at edge k+1.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `LOCK_STABLE_CYCLES`=8, `MAX_RETRIES`=3.

1. Clean bring-up:
   - Stimulus: release `rst`; `pll_locked` rises at edge 10 and stays high.
   - Required: `pll_rst` is high on edges 0–3; `sys_rst` falls and `ready` rises at edge 21; `retry_count`=0.
2. Timeout to FAIL:
   - Stimulus: `pll_locked` held at 0.
   - Required: `pll_rst` pulses for 4 cycles, 3 times, 36 cycles apart; `retry_count` goes 1, 2, 3; `fail`=1 at edge 108 with `pll_rst` stuck at 1.
   - Stimulus: then `restart`.
   - Required: `fail`=0 and `retry_count`=0.
3. Unstable lock:
   - Stimulus: lock high for 5 cycles, low, then high continuously.
   - Required: `sys_rst` stays 1 through the drop; release occurs 11 edges after the final rise.
4. Lock loss in RUN:
   - Stimulus: drop `pll_locked` while in RUN.
   - Required: `sys_rst`=1 and `ready`=0 three edges later; `lock_lost_count`=1; a full re-sequence follows.
   - Stimulus: repeat the drop 300 times.
   - Required: `lock_lost_count` saturates at 255.
5. Priority and reset:
   - Stimulus: `restart` on the same edge as a lock drop in RUN.
   - Required: `lock_lost_count` is unchanged.
   - Stimulus: `rst` asserted in STABLE.
   - Required: all outputs return to reset values on the next edge.
